tilemap_port_arbiter: RTL and testbench

- Controller that shares one dual-port tile RAM (one read port, one write port, 1-cycle registered read) between the VGA scanout engine, game-logic collision reads, game-logic tile writes and a full-board clear sweep.
- Sits between the snake game engine, the VGA pixel pipeline and the tile RAM instance, and drives every RAM control/address/data input.
- VGA reads have absolute priority. The clear sweep owns the write port while active.

---
 rtl/tilemap_pkg.sv | 15 +
 rtl/tilemap_port_arbiter_clear.sv | 62 ++++++
 rtl/tilemap_port_arbiter.sv | 121 ++++++++++++
 tb/tb_tilemap_port_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tilemap_pkg.sv
// Shared types and board constants for the tile RAM port arbiter.
package tilemap_pkg;

    typedef enum logic [1:0] {OWN_NONE, OWN_VGA, OWN_GAME} rd_owner_t;
    typedef enum logic {WR_IDLE, WR_CLEAR} wr_state_t;

    localparam int BOARD_W = 40;
    localparam int BOARD_H = 30;
    localparam int NTILES  = BOARD_W * BOARD_H;

    localparam logic [3:0] TILE_EMPTY = 4'd0;
    localparam logic [3:0] TILE_SNAKE = 4'd1;
    localparam logic [3:0] TILE_FOOD  = 4'd2;

endpackage

// File: rtl/tilemap_port_arbiter_clear.sv
// Full-board clear sequencer: write FSM, address counter, busy and done pulse.
module tile_clear_seq
    import tilemap_pkg::*;
#(
    parameter int AWIDTH = 11,
    parameter int NTILES = 1200
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_start,
    output logic              busy,
    output logic              done,
    output logic [AWIDTH-1:0] count
);

    localparam logic [AWIDTH-1:0] LAST = AWIDTH'(NTILES - 1);

    wr_state_t         state;
    wr_state_t         state_next;
    logic [AWIDTH-1:0] count_next;
    logic              done_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WR_IDLE;
            count <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            done  <= done_next;
        end
    end

    // clear_start is only looked at in IDLE, so a restart request mid-sweep is dropped
    always_comb begin
        state_next = state;
        count_next = count;
        done_next  = 1'b0;
        busy       = 1'b0;
        case (state)
            WR_IDLE: begin
                if (clear_start) begin
                    state_next = WR_CLEAR;
                    count_next = '0;
                end
            end
            WR_CLEAR: begin
                busy = 1'b1;
                if (count == LAST) begin
                    state_next = WR_IDLE;
                    count_next = '0;
                    done_next  = 1'b1;
                end else begin
                    count_next = count + AWIDTH'(1);
                end
            end
            default: state_next = WR_IDLE;
        endcase
    end

endmodule

// File: rtl/tilemap_port_arbiter.sv
// Shares one tile RAM between VGA scanout, game reads/writes and the clear sweep.
module tilemap_port_arbiter
    import tilemap_pkg::*;
#(
    parameter int               DWIDTH    = 4,
    parameter int               AWIDTH    = 11,
    parameter int               NTILES    = 1200,
    parameter logic [DWIDTH-1:0] CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vga_req,
    input  logic [AWIDTH-1:0] vga_addr,
    output logic              vga_valid,
    output logic [DWIDTH-1:0] vga_data,
    input  logic              gr_req,
    input  logic [AWIDTH-1:0] gr_addr,
    output logic              gr_gnt,
    output logic              gr_valid,
    output logic [DWIDTH-1:0] gr_data,
    input  logic              gw_req,
    input  logic [AWIDTH-1:0] gw_addr,
    input  logic [DWIDTH-1:0] gw_data,
    output logic              gw_gnt,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic              clear_done,
    output logic              mem_re,
    output logic [AWIDTH-1:0] mem_raddr,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_waddr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata
);

    logic [AWIDTH-1:0] clear_count;
    rd_owner_t         owner;
    rd_owner_t         owner_next;
    logic              byp;
    logic              byp_next;
    logic [DWIDTH-1:0] byp_data;
    logic [DWIDTH-1:0] vga_hold;
    logic [DWIDTH-1:0] gr_hold;
    logic [DWIDTH-1:0] gr_rd;

    tile_clear_seq #(
        .AWIDTH (AWIDTH),
        .NTILES (NTILES)
    ) u_clear (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_start (clear_start),
        .busy        (clear_busy),
        .done        (clear_done),
        .count       (clear_count)
    );

    // VGA always wins the read port; the game read waits while vga_req is high
    always_comb begin
        mem_re     = 1'b0;
        mem_raddr  = vga_addr;
        gr_gnt     = 1'b0;
        owner_next = OWN_NONE;
        if (rst_n) begin
            if (vga_req) begin
                mem_re     = 1'b1;
                owner_next = OWN_VGA;
            end else if (gr_req) begin
                mem_re     = 1'b1;
                mem_raddr  = gr_addr;
                gr_gnt     = 1'b1;
                owner_next = OWN_GAME;
            end
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = gw_addr;
        mem_wdata = gw_data;
        gw_gnt    = 1'b0;
        if (rst_n) begin
            if (clear_busy) begin
                mem_we    = 1'b1;
                mem_waddr = clear_count;
                mem_wdata = CLEAR_VAL;
            end else if (gw_req) begin
                mem_we = 1'b1;
                gw_gnt = 1'b1;
            end
        end
    end

    // RAM returns pre-write data on a same-address collision, so game reads take the write value
    assign byp_next = gr_gnt && mem_we && (mem_waddr == gr_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner    <= OWN_NONE;
            byp      <= 1'b0;
            vga_hold <= '0;
            gr_hold  <= '0;
        end else begin
            owner <= owner_next;
            byp   <= byp_next;
            if (owner == OWN_VGA) vga_hold <= mem_rdata;
            if (owner == OWN_GAME) gr_hold <= gr_rd;
        end
    end

    always_ff @(posedge clk) begin
        byp_data <= mem_wdata;
    end

    assign gr_rd     = byp ? byp_data : mem_rdata;
    assign vga_valid = (owner == OWN_VGA);
    assign gr_valid  = (owner == OWN_GAME);
    assign vga_data  = vga_valid ? mem_rdata : vga_hold;
    assign gr_data   = gr_valid ? gr_rd : gr_hold;

endmodule

// File: tb/tb_tilemap_port_arbiter.sv
// Scoreboard bench for tilemap_port_arbiter with a behavioural registered-read tile RAM.
module tb_tilemap_port_arbiter;

    localparam int DW = 4;
    localparam int AW = 11;
    localparam int NT = 1200;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          vga_req, gr_req, gw_req, clear_start;
    logic [AW-1:0] vga_addr, gr_addr, gw_addr;
    logic [DW-1:0] gw_data;
    logic          vga_valid, gr_gnt, gr_valid, gw_gnt, clear_busy, clear_done;
    logic [DW-1:0] vga_data, gr_data;
    logic          mem_re, mem_we;
    logic [AW-1:0] mem_raddr, mem_waddr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] vq[$];
    logic [DW-1:0] gq[$];
    logic [DW-1:0] exp_mem [0:2**AW-1];
    logic [DW-1:0] ram [0:2**AW-1];
    logic          ram_init = 1'b0;

    always #5 clk = ~clk;

    tilemap_port_arbiter #(
        .DWIDTH(DW), .AWIDTH(AW), .NTILES(NT), .CLEAR_VAL(4'h0)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_valid(vga_valid), .vga_data(vga_data),
        .gr_req(gr_req), .gr_addr(gr_addr), .gr_gnt(gr_gnt), .gr_valid(gr_valid), .gr_data(gr_data),
        .gw_req(gw_req), .gw_addr(gw_addr), .gw_data(gw_data), .gw_gnt(gw_gnt),
        .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
        .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_we(mem_we), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [DW-1:0] pat(input int i);
        return DW'((i * 7 + 3) % 16);
    endfunction

    // Tile RAM model: write-first ordering not modelled, reads return old contents
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 2**AW; i++) ram[i] <= pat(i);
            ram_init <= 1'b1;
        end else if (mem_we) begin
            ram[mem_waddr] <= mem_wdata;
        end
        if (mem_re) mem_rdata <= ram[mem_raddr];
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops one expected word per valid strobe
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (vga_valid) begin
                if (vq.size() == 0) check("vga_unexpected_valid", 1, 0);
                else check("vga_data", {28'd0, vga_data}, {28'd0, vq.pop_front()});
            end
            if (gr_valid) begin
                if (gq.size() == 0) check("gr_unexpected_valid", 1, 0);
                else check("gr_data", {28'd0, gr_data}, {28'd0, gq.pop_front()});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step();
        vga_req = 0; gr_req = 0; gw_req = 0; clear_start = 0;
    endtask

    task automatic rd_game(input int a);
        step();
        vga_req = 0; gw_req = 0; gr_req = 1; gr_addr = AW'(a);
        #1;
        check("gr_gnt_read", {31'd0, gr_gnt}, 1);
        gq.push_back(exp_mem[a]);
    endtask

    task automatic wr_game(input int a, input logic [DW-1:0] d);
        step();
        gr_req = 0; gw_req = 1; gw_addr = AW'(a); gw_data = d;
        #1;
        check("gw_gnt_write", {31'd0, gw_gnt}, 1);
        exp_mem[a] = d;
    endtask

    initial begin
        int bad;
        int busy_cnt;
        for (int i = 0; i < 2**AW; i++) exp_mem[i] = pat(i);
        rst_n = 0; vga_req = 1; gr_req = 1; gw_req = 1; clear_start = 0;
        vga_addr = '0; gr_addr = '0; gw_addr = '0; gw_data = '0;
        repeat (3) step();
        check("rst_mem_re", {31'd0, mem_re}, 0);
        check("rst_mem_we", {31'd0, mem_we}, 0);
        check("rst_valids", {30'd0, vga_valid, gr_valid}, 0);
        check("rst_clear", {30'd0, clear_busy, clear_done}, 0);
        check("rst_data", {24'd0, vga_data, gr_data}, 0);
        vga_req = 0; gr_req = 0; gw_req = 0;
        rst_n = 1;
        idle();

        // VGA beats a simultaneous game read
        step();
        vga_req = 1; vga_addr = 11'd5; gr_req = 1; gr_addr = 11'd7;
        #1;
        check("prio_raddr", {21'd0, mem_raddr}, 5);
        check("prio_gr_gnt", {31'd0, gr_gnt}, 0);
        vq.push_back(exp_mem[5]);
        step();
        vga_req = 0;
        #1;
        check("prio_gr_gnt_after", {31'd0, gr_gnt}, 1);
        check("prio_raddr_after", {21'd0, mem_raddr}, 7);
        gq.push_back(exp_mem[7]);
        idle();

        // Write then read back, then same-cycle bypass, then non-matching address
        wr_game(100, 4'h3);
        rd_game(100);
        step();
        gw_req = 1; gw_addr = 11'd100; gw_data = 4'h9; gr_req = 1; gr_addr = 11'd100;
        #1;
        check("byp_gr_gnt", {31'd0, gr_gnt}, 1);
        gq.push_back(4'h9);
        exp_mem[100] = 4'h9;
        rd_game(100);
        step();
        gw_req = 1; gw_addr = 11'd101; gw_data = 4'h5; gr_req = 1; gr_addr = 11'd100;
        #1;
        gq.push_back(exp_mem[100]);
        exp_mem[101] = 4'h5;
        rd_game(101);
        idle();

        // VGA burst starves the held game read until one gap
        bad = 0;
        for (int i = 0; i < 640; i++) begin
            step();
            vga_req = 1; vga_addr = AW'(i); gr_req = 1; gr_addr = 11'd50;
            #1;
            if (gr_gnt !== 1'b0 || mem_raddr !== AW'(i)) bad++;
            vq.push_back(exp_mem[i]);
        end
        check("burst_bad_cycles", bad, 0);
        step();
        vga_req = 0;
        #1;
        check("burst_gap_gr_gnt", {31'd0, gr_gnt}, 1);
        gq.push_back(exp_mem[50]);
        step();
        vga_req = 1; vga_addr = 11'd700; gr_req = 0;
        #1;
        check("burst_resume_gr_gnt", {31'd0, gr_gnt}, 0);
        vq.push_back(exp_mem[700]);
        idle();

        // Full clear with a held write from cycle 10 and a restart attempt at cycle 50
        step();
        clear_start = 1;
        #1;
        check("clr_start_busy", {31'd0, clear_busy}, 0);
        bad = 0; busy_cnt = 0;
        for (int k = 1; k <= NT; k++) begin
            step();
            clear_start = (k == 50);
            if (k == 10) begin gw_req = 1; gw_addr = 11'd1500; gw_data = 4'hC; end
            #1;
            if (clear_busy === 1'b1) busy_cnt++;
            if ({clear_busy, mem_we, mem_wdata, gw_gnt, clear_done} !== {1'b1, 1'b1, 4'h0, 1'b0, 1'b0}
                || mem_waddr !== AW'(k - 1)) bad++;
        end
        check("clr_sweep_bad_cycles", bad, 0);
        check("clr_busy_cycles", busy_cnt, NT);
        step();
        clear_start = 0;
        #1;
        check("clr_done_pulse", {31'd0, clear_done}, 1);
        check("clr_busy_end", {31'd0, clear_busy}, 0);
        check("clr_pending_gw_gnt", {31'd0, gw_gnt}, 1);
        check("clr_pending_waddr", {21'd0, mem_waddr}, 1500);
        for (int i = 0; i < NT; i++) exp_mem[i] = 4'h0;
        exp_mem[1500] = 4'hC;
        step();
        gw_req = 0;
        #1;
        check("clr_done_once", {31'd0, clear_done}, 0);
        rd_game(0);
        rd_game(600);
        rd_game(1199);
        rd_game(1200);
        rd_game(1500);
        idle();

        // Reset in the middle of a clear
        wr_game(299, 4'h7);
        wr_game(300, 4'h6);
        step();
        gw_req = 0; clear_start = 1;
        for (int k = 1; k <= 300; k++) begin
            step();
            clear_start = 0;
        end
        step();
        check("abort_waddr", {21'd0, mem_waddr}, 300);
        rst_n = 0;
        #1;
        check("abort_busy", {31'd0, clear_busy}, 0);
        check("abort_we", {31'd0, mem_we}, 0);
        for (int i = 0; i < 2; i++) begin
            step();
            check("abort_done_rst", {31'd0, clear_done}, 0);
        end
        rst_n = 1;
        step();
        check("abort_idle_busy", {31'd0, clear_busy}, 0);
        check("abort_no_done", {31'd0, clear_done}, 0);
        check("abort_idle_we", {31'd0, mem_we}, 0);
        for (int i = 0; i < 300; i++) exp_mem[i] = 4'h0;
        rd_game(299);
        rd_game(300);
        rd_game(298);
        idle();

        repeat (4) step();
        check("vga_queue_empty", vq.size(), 0);
        check("gr_queue_empty", gq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
